// File: rtl/instruction_fetch.sv
// RV32E instruction fetch stage: PC generation, credit-limited memory requests
// and an in-order {pc, instr} queue feeding the IF/ID register.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc0_IF,
  output logic [31:0] pc4_IF,
  output logic [31:0] instruction_IF,
  output logic        invalid_IF
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instruction_fetch: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("instruction_fetch: RESET_PC must be word aligned");
  end

  logic [31:0]   fetch_pc;
  logic [31:0]   pend_pc [FIFO_DEPTH];
  logic [PW-1:0] pend_wr_ptr;
  logic [PW-1:0] pend_rd_ptr;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  logic [31:0]   q_pc    [FIFO_DEPTH];
  logic [31:0]   q_instr [FIFO_DEPTH];
  logic [PW-1:0] q_wr_ptr;
  logic [PW-1:0] q_rd_ptr;
  logic [CW-1:0] count;

  logic [CW:0]   in_use;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp_take;
  logic          q_push;
  logic          q_pop;
  logic          head_valid;
  logic          unused_lsbs;

  // Credit covers both in-flight requests and queued entries, so a response
  // always finds a free queue slot; a same-cycle pop earns no credit.
  assign in_use    = {1'b0, outstanding} + {1'b0, count};
  assign credit_ok = in_use < DEPTH_W;

  assign imem_req_valid = rst_n && !redirect && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding are stale (e.g. from before a reset).
  assign rsp_take = imem_rsp_valid && (outstanding != '0);
  assign q_push   = rsp_take && (discard == '0) && !redirect;
  assign q_pop    = !redirect && !stall && (count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      pend_wr_ptr <= '0;
      pend_rd_ptr <= '0;
      outstanding <= '0;
      discard     <= '0;
      q_wr_ptr    <= '0;
      q_rd_ptr    <= '0;
      count       <= '0;
    end else begin
      if (req_fire) pend_wr_ptr <= pend_wr_ptr + PW'(1);
      if (rsp_take) pend_rd_ptr <= pend_rd_ptr + PW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);

      if (redirect) begin
        // Every request still in flight after this edge belongs to the old path.
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        discard  <= outstanding - CW'(rsp_take);
        q_wr_ptr <= '0;
        q_rd_ptr <= '0;
        count    <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_take && (discard != '0)) discard <= discard - CW'(1);
        if (q_push) q_wr_ptr <= q_wr_ptr + PW'(1);
        if (q_pop)  q_rd_ptr <= q_rd_ptr + PW'(1);
        count <= count + CW'(q_push) - CW'(q_pop);
      end
    end
  end

  // Storage needs no reset: entries are only read while tracked by the counters.
  always_ff @(posedge clk) begin
    if (req_fire) pend_pc[pend_wr_ptr] <= fetch_pc;
    if (q_push) begin
      q_pc[q_wr_ptr]    <= pend_pc[pend_rd_ptr];
      q_instr[q_wr_ptr] <= imem_rsp_data;
    end
  end

  assign head_valid     = (count != '0);
  assign invalid_IF     = !head_valid;
  assign pc0_IF         = head_valid ? q_pc[q_rd_ptr] : 32'h0;
  assign pc4_IF         = head_valid ? (q_pc[q_rd_ptr] + 32'd4) : 32'h0;
  assign instruction_IF = head_valid ? q_instr[q_rd_ptr] : 32'h0000_0013;

  assign unused_lsbs = ^redirect_pc[1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stream, stall, redirect, ready stalls,
// PC wrap-around and mid-operation reset, with a 1-cycle memory model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] pc0_IF;
  logic [31:0] pc4_IF;
  logic [31:0] instruction_IF;
  logic        invalid_IF;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mem_auto;
  logic        hs_now;
  logic [31:0] addr_now;
  int          hs_total;
  int          consumed_total;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pc0_IF(pc0_IF), .pc4_IF(pc4_IF), .instruction_IF(instruction_IF), .invalid_IF(invalid_IF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  // Advance one cycle; inputs are set while clk is low, sampled 1 unit later.
  task automatic tick();
    #1;
    hs_now   = imem_req_valid && imem_req_ready;
    addr_now = imem_req_addr;
    if (hs_now) hs_total++;
    if (rst_n && !invalid_IF && !stall && !redirect) consumed_total++;
    @(posedge clk);
    @(negedge clk);
    if (mem_auto) begin
      imem_rsp_valid = hs_now;
      imem_rsp_data  = hs_now ? mem_word(addr_now) : 32'h0;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    tick();
    rst_n = 1'b1;
    hs_total = 0;
    consumed_total = 0;
  endtask

  task automatic test_reset();
    mem_auto = 1'b1;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    tick();
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL reset_req_addr: got %h want 00000000", imem_req_addr); end
    n_cmp++; if (invalid_IF !== 1'b1) begin n_bad++; $display("FAIL reset_invalid: got %b want 1", invalid_IF); end
    n_cmp++; if (instruction_IF !== 32'h13) begin n_bad++; $display("FAIL reset_instr: got %h want 00000013", instruction_IF); end
    n_cmp++; if (pc0_IF !== 32'h0) begin n_bad++; $display("FAIL reset_pc0: got %h want 00000000", pc0_IF); end
    n_cmp++; if (pc4_IF !== 32'h0) begin n_bad++; $display("FAIL reset_pc4: got %h want 00000000", pc4_IF); end
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    logic [31:0] req_exp;
    int n_del;
    mem_auto = 1'b1;
    apply_reset();
    imem_req_ready = 1'b1;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL stream_first_valid: got %b want 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL stream_first_addr: got %h want 00000000", imem_req_addr); end
    tick();
    #1;
    n_cmp++; if (imem_req_addr !== 32'h4) begin n_bad++; $display("FAIL stream_second_addr: got %h want 00000004", imem_req_addr); end
    tick();
    n_cmp++; if (invalid_IF !== 1'b0) begin n_bad++; $display("FAIL stream_first_out_invalid: got %b want 0", invalid_IF); end
    n_cmp++; if (pc0_IF !== 32'h0) begin n_bad++; $display("FAIL stream_first_pc0: got %h want 00000000", pc0_IF); end
    n_cmp++; if (pc4_IF !== 32'h4) begin n_bad++; $display("FAIL stream_first_pc4: got %h want 00000004", pc4_IF); end
    n_cmp++; if (instruction_IF !== mem_word(32'h0)) begin n_bad++; $display("FAIL stream_first_instr: got %h want %h", instruction_IF, mem_word(32'h0)); end
    exp_pc = 32'h0;
    req_exp = 32'h8;
    n_del = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (!invalid_IF) begin
        n_cmp++; if (pc0_IF !== exp_pc) begin n_bad++; $display("FAIL stream_pc0: got %h want %h", pc0_IF, exp_pc); end
        n_cmp++; if (pc4_IF !== exp_pc + 32'd4) begin n_bad++; $display("FAIL stream_pc4: got %h want %h", pc4_IF, exp_pc + 32'd4); end
        n_cmp++; if (instruction_IF !== mem_word(exp_pc)) begin n_bad++; $display("FAIL stream_instr: got %h want %h", instruction_IF, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        n_del++;
      end
      if (imem_req_valid) begin
        n_cmp++; if (imem_req_addr !== req_exp) begin n_bad++; $display("FAIL stream_req_addr: got %h want %h", imem_req_addr, req_exp); end
        req_exp = req_exp + 32'd4;
      end
      tick();
      n_cmp++; if (hs_total - consumed_total > 2) begin n_bad++; $display("FAIL stream_credit: got %0d want <=2", hs_total - consumed_total); end
    end
    n_cmp++; if (n_del < 6) begin n_bad++; $display("FAIL stream_delivered: got %0d want >=6", n_del); end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    logic [31:0] held;
    int wait_cyc;
    mem_auto = 1'b1;
    apply_reset();
    imem_req_ready = 1'b1;
    exp_pc = 32'h0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (!invalid_IF) begin
        n_cmp++; if (pc0_IF !== exp_pc) begin n_bad++; $display("FAIL stall_pre_pc0: got %h want %h", pc0_IF, exp_pc); end
        exp_pc = exp_pc + 32'd4;
      end
      tick();
    end
    wait_cyc = 0;
    while (invalid_IF && wait_cyc < 4) begin
      tick();
      wait_cyc++;
    end
    n_cmp++; if (invalid_IF !== 1'b0) begin n_bad++; $display("FAIL stall_head_timeout: got invalid %b want 0", invalid_IF); end
    held = exp_pc;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (invalid_IF !== 1'b0) begin n_bad++; $display("FAIL stall_hold_invalid: got %b want 0", invalid_IF); end
      n_cmp++; if (pc0_IF !== held) begin n_bad++; $display("FAIL stall_hold_pc0: got %h want %h", pc0_IF, held); end
      n_cmp++; if (instruction_IF !== mem_word(held)) begin n_bad++; $display("FAIL stall_hold_instr: got %h want %h", instruction_IF, mem_word(held)); end
      tick();
      n_cmp++; if (hs_total - consumed_total > 2) begin n_bad++; $display("FAIL stall_credit: got %0d want <=2", hs_total - consumed_total); end
    end
    stall = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (!invalid_IF) begin
        n_cmp++; if (pc0_IF !== exp_pc) begin n_bad++; $display("FAIL stall_post_pc0: got %h want %h", pc0_IF, exp_pc); end
        n_cmp++; if (instruction_IF !== mem_word(exp_pc)) begin n_bad++; $display("FAIL stall_post_instr: got %h want %h", instruction_IF, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
      end
      tick();
      n_cmp++; if (hs_total - consumed_total > 2) begin n_bad++; $display("FAIL stall_post_credit: got %0d want <=2", hs_total - consumed_total); end
    end
    n_cmp++; if (exp_pc - held < 32'd24) begin n_bad++; $display("FAIL stall_post_progress: got %h want >= %h", exp_pc, held + 32'd24); end
  endtask

  task automatic test_redirect();
    mem_auto = 1'b0;
    apply_reset();
    imem_req_ready = 1'b1;
    #1;
    n_cmp++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL redir_req0: got %h want 00000000", imem_req_addr); end
    tick();
    #1;
    n_cmp++; if (imem_req_addr !== 32'h4) begin n_bad++; $display("FAIL redir_req1: got %h want 00000004", imem_req_addr); end
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h0);
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL redir_valid_low: got %b want 0", imem_req_valid); end
    tick();
    redirect = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h4);
    #1;
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL redir_target_valid: got %b want 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h100) begin n_bad++; $display("FAIL redir_target_addr: got %h want 00000100", imem_req_addr); end
    n_cmp++; if (invalid_IF !== 1'b1) begin n_bad++; $display("FAIL redir_n1_invalid: got %b want 1", invalid_IF); end
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h100);
    #1;
    n_cmp++; if (invalid_IF !== 1'b1) begin n_bad++; $display("FAIL redir_n2_invalid: got %b (pc0 %h) want 1", invalid_IF, pc0_IF); end
    n_cmp++; if (imem_req_addr !== 32'h104) begin n_bad++; $display("FAIL redir_next_addr: got %h want 00000104", imem_req_addr); end
    tick();
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    #1;
    n_cmp++; if (invalid_IF !== 1'b0) begin n_bad++; $display("FAIL redir_n3_invalid: got %b want 0", invalid_IF); end
    n_cmp++; if (pc0_IF !== 32'h100) begin n_bad++; $display("FAIL redir_n3_pc0: got %h want 00000100", pc0_IF); end
    n_cmp++; if (pc4_IF !== 32'h104) begin n_bad++; $display("FAIL redir_n3_pc4: got %h want 00000104", pc4_IF); end
    n_cmp++; if (instruction_IF !== mem_word(32'h100)) begin n_bad++; $display("FAIL redir_n3_instr: got %h want %h", instruction_IF, mem_word(32'h100)); end
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h104);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (pc0_IF !== 32'h104 || invalid_IF !== 1'b0) begin n_bad++; $display("FAIL redir_follow_pc0: got %h/%b want 00000104/0", pc0_IF, invalid_IF); end
    tick();
  endtask

  task automatic test_ready_stall();
    mem_auto = 1'b1;
    apply_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL rdy_hold_valid: got %b want 1", imem_req_valid); end
      n_cmp++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL rdy_hold_addr: got %h want 00000000", imem_req_addr); end
      tick();
    end
    n_cmp++; if (hs_total !== 0) begin n_bad++; $display("FAIL rdy_no_hs: got %0d want 0", hs_total); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    n_cmp++; if (hs_total !== 1) begin n_bad++; $display("FAIL rdy_one_hs: got %0d want 1", hs_total); end
    #1;
    n_cmp++; if (imem_req_addr !== 32'h4) begin n_bad++; $display("FAIL rdy_next_addr: got %h want 00000004", imem_req_addr); end
    tick();
    n_cmp++; if (hs_total !== 1) begin n_bad++; $display("FAIL rdy_still_one_hs: got %0d want 1", hs_total); end
    n_cmp++; if (pc0_IF !== 32'h0 || invalid_IF !== 1'b0) begin n_bad++; $display("FAIL rdy_out: got %h/%b want 00000000/0", pc0_IF, invalid_IF); end
    tick();
  endtask

  task automatic test_wrap();
    mem_auto = 1'b1;
    apply_reset();
    imem_req_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_redir_valid: got %b want 0", imem_req_valid); end
    tick();
    redirect = 1'b0;
    #1;
    n_cmp++; if (imem_req_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_target_addr: got %h want fffffffc", imem_req_addr); end
    tick();
    #1;
    n_cmp++; if (imem_req_addr !== 32'h0 || imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_next_addr: got %h/%b want 00000000/1", imem_req_addr, imem_req_valid); end
    n_cmp++; if (invalid_IF !== 1'b1) begin n_bad++; $display("FAIL wrap_early_invalid: got %b want 1", invalid_IF); end
    tick();
    n_cmp++; if (pc0_IF !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_pc0: got %h want fffffffc", pc0_IF); end
    n_cmp++; if (pc4_IF !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4: got %h want 00000000", pc4_IF); end
    n_cmp++; if (instruction_IF !== mem_word(32'hFFFF_FFFC)) begin n_bad++; $display("FAIL wrap_instr: got %h want %h", instruction_IF, mem_word(32'hFFFF_FFFC)); end
    tick();
  endtask

  task automatic test_reset_midop();
    mem_auto = 1'b0;
    apply_reset();
    imem_req_ready = 1'b1;
    tick();
    tick();
    n_cmp++; if (hs_total !== 2) begin n_bad++; $display("FAIL midrst_setup_hs: got %0d want 2", hs_total); end
    rst_n = 1'b0; imem_req_ready = 1'b0;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", imem_req_valid); end
    tick();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL midrst_req: got %b/%h want 1/00000000", imem_req_valid, imem_req_addr); end
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (invalid_IF !== 1'b1) begin n_bad++; $display("FAIL midrst_stale_ignored: got invalid %b pc0 %h want 1", invalid_IF, pc0_IF); end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h0);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    n_cmp++; if (invalid_IF !== 1'b0 || pc0_IF !== 32'h0) begin n_bad++; $display("FAIL midrst_first_pc0: got %b/%h want 0/00000000", invalid_IF, pc0_IF); end
    n_cmp++; if (instruction_IF !== mem_word(32'h0)) begin n_bad++; $display("FAIL midrst_first_instr: got %h want %h", instruction_IF, mem_word(32'h0)); end
    tick();
    n_cmp++; if (invalid_IF !== 1'b1) begin n_bad++; $display("FAIL midrst_drained: got %b want 1", invalid_IF); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_ready_stall();
    test_wrap();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
